ctrl_reg_writer: RTL and testbench

CTRL_REG_WRITER -- requirements
Module: ctrl_reg_writer

---
 rtl/ctrl_reg_writer.sv | 169 ++++++++++++++++
 tb/tb_ctrl_reg_writer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_reg_writer.sv
// Command FIFO plus LO/HI/GAP sequencer that splits each 32-bit payload into two 16-bit words.
// Optional shadow register file is compiled in with `define CTRL_WRITER_SHADOW_EN.
module ctrl_reg_writer #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_wa,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        wen,
    output logic [1:0]  wa,
    output logic [15:0] di,
    output logic        busy
`ifdef CTRL_WRITER_SHADOW_EN
    ,
    input  logic [1:0]  rd_wa,
    output logic [31:0] rd_data
`endif
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_C    = DEPTH[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0]   ZERO_C    = (DEPTH_LOG2 + 1)'(1'b0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE_C = (DEPTH_LOG2 + 1)'(1'b1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE_C = DEPTH_LOG2'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [33:0]           mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [DEPTH_LOG2:0]   count_s;
    logic                  empty_s;
    logic                  full_s;
    logic                  push_s;
    logic                  pop_s;
    logic [33:0]           head_s;
    logic                  wen_r;
    logic [1:0]            wa_r;
    logic [15:0]           di_r;
    logic [15:0]           hi_r;
    logic                  busy_r;

    assign empty_s   = (count_r == ZERO_C);
    assign full_s    = (count_r == FULL_C);
    // Ready looks only at the stored count, so a same-cycle pop never frees a slot early.
    assign cmd_ready = ~rst & ~full_s;
    assign push_s    = cmd_valid & cmd_ready;
    assign head_s    = mem_r[rd_ptr_r];

    assign wen  = wen_r;
    assign wa   = wa_r;
    assign di   = di_r;
    assign busy = busy_r;

    // Next-state logic; a pop happens only when leaving IDLE or GAP towards LO.
    always_comb begin
        state_s = state_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    state_s = ST_LO;
                    pop_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LO:   state_s = ST_HI;
            ST_HI:   state_s = ST_GAP;
            ST_GAP: begin
                if (!empty_s) begin
                    state_s = ST_LO;
                    pop_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FIFO occupancy after this edge's push/pop.
    always_comb begin
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_s = count_r + CNT_ONE_C;
            2'b01:   count_s = count_r - CNT_ONE_C;
            default: count_s = count_r;
        endcase
    end

    // FIFO storage; no reset needed since occupancy is tracked by count_r.
    always_ff @(negedge sclk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {cmd_wa, cmd_data};
        end
    end

    // Sequencer, FIFO pointers and registered write-port outputs.
    always_ff @(negedge sclk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= ZERO_C;
            wr_ptr_r <= DEPTH_LOG2'(1'b0);
            rd_ptr_r <= DEPTH_LOG2'(1'b0);
            wen_r    <= 1'b0;
            wa_r     <= 2'd0;
            di_r     <= 16'h0000;
            hi_r     <= 16'h0000;
            busy_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            busy_r  <= (count_s != ZERO_C) | (state_s != ST_IDLE);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                wen_r    <= 1'b1;
                wa_r     <= head_s[33:32];
                di_r     <= head_s[15:0];
                hi_r     <= head_s[31:16];
            end else if (state_r == ST_LO) begin
                wen_r <= 1'b0;
                di_r  <= hi_r;
            end else begin
                wen_r <= 1'b0;
            end
        end
    end

`ifdef CTRL_WRITER_SHADOW_EN
    logic [15:0] lo_r;
    logic [31:0] shadow_r [4];

    // Shadow copy is committed on the HI->GAP edge, so an aborted sequence never lands.
    always_ff @(negedge sclk) begin
        if (rst) begin
            lo_r        <= 16'h0000;
            shadow_r[0] <= 32'h0000_0000;
            shadow_r[1] <= 32'h0000_0000;
            shadow_r[2] <= 32'h0000_00ff;
            shadow_r[3] <= 32'h0000_0000;
        end else begin
            if (pop_s) begin
                lo_r <= head_s[15:0];
            end
            if (state_r == ST_HI) begin
                shadow_r[wa_r] <= {hi_r, lo_r};
            end
        end
    end

    assign rd_data = shadow_r[rd_wa];
`endif

endmodule

// File: tb/tb_ctrl_reg_writer.sv
// Scoreboard bench for ctrl_reg_writer: stimulus pushes expected writes, a monitor checks wen/wa/di.
module tb_ctrl_reg_writer;

    logic        sclk = 1'b1;
    logic        rst;
    logic        cmd_valid;
    logic [1:0]  cmd_wa;
    logic [31:0] cmd_data;
    logic        cmd_ready;
    logic        wen;
    logic [1:0]  wa;
    logic [15:0] di;
    logic        busy;
`ifdef CTRL_WRITER_SHADOW_EN
    logic [1:0]  rd_wa = 2'd0;
    logic [31:0] rd_data;
`endif

    ctrl_reg_writer #(.DEPTH_LOG2(2)) dut (
        .sclk      (sclk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_wa    (cmd_wa),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .wen       (wen),
        .wa        (wa),
        .di        (di),
        .busy      (busy)
`ifdef CTRL_WRITER_SHADOW_EN
        ,
        .rd_wa     (rd_wa),
        .rd_data   (rd_data)
`endif
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [1:0]  wa;
        logic [31:0] data;
        int          gap;
        int          lat;
        int          push_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   wen_count = 0;
    int   last_wen_cyc = 0;

    always @(posedge sclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks every write strobe and the high half-word that follows it.
    always begin : monitor
        exp_t cur;
        bit   pend_hi;
        pend_hi = 1'b0;
        forever begin
            @(posedge sclk);
            #1;
            if (pend_hi) begin
                chk("hi_wen", {63'd0, wen}, 64'd0);
                chk("hi_di", {48'd0, di}, {48'd0, cur.data[31:16]});
                chk("hi_wa", {62'd0, wa}, {62'd0, cur.wa});
                pend_hi = 1'b0;
            end
            if (wen === 1'b1) begin
                wen_count++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_wen: got wa=%0d di=0x%0h with nothing expected", wa, di);
                end else begin
                    cur = exp_q.pop_front();
                    chk("lo_wa", {62'd0, wa}, {62'd0, cur.wa});
                    chk("lo_di", {48'd0, di}, {48'd0, cur.data[15:0]});
                    if (cur.lat != 0) chk("latency", 64'(cyc - cur.push_cyc), 64'(cur.lat));
                    if (cur.gap != 0) chk("spacing", 64'(cyc - last_wen_cyc), 64'(cur.gap));
                    pend_hi = 1'b1;
                end
                last_wen_cyc = cyc;
            end
        end
    end

    // Offer one command; the expectation is queued on the edge it is accepted.
    task automatic send(input logic [1:0] w, input logic [31:0] d, input int gap, input int lat,
                        output int tries);
        exp_t e;
        logic rdy;
        bit   done;
        done  = 1'b0;
        tries = 0;
        cmd_valid = 1'b1;
        cmd_wa    = w;
        cmd_data  = d;
        while (!done && tries < 50) begin
            #1;
            rdy = cmd_ready;
            @(negedge sclk);
            tries++;
            if (rdy === 1'b1) begin
                done = 1'b1;
                e.wa = w; e.data = d; e.gap = gap; e.lat = lat; e.push_cyc = cyc;
                exp_q.push_back(e);
            end
            @(posedge sclk);
        end
        cmd_valid = 1'b0;
        chk("send_accepted", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_idle(output int idle_cyc);
        bit ok;
        ok = 1'b0;
        idle_cyc = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge sclk);
            #1;
            if (exp_q.size() == 0 && busy === 1'b0) begin
                ok = 1'b1;
                idle_cyc = cyc;
            end
        end
        chk("idle_reached", {63'd0, ok}, 64'd1);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t;
        int ic;
        int saved;
        logic [1:0]  bw [4];
        logic [31:0] bd [4];
        logic [1:0]  fw [7];
        logic [31:0] fd [7];
        bw = '{2'd1, 2'd2, 2'd3, 2'd1};
        bd = '{32'h1111_aaaa, 32'h2222_bbbb, 32'h3333_cccc, 32'h4444_dddd};
        fw = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        fd = '{32'ha001_0001, 32'ha002_0002, 32'ha003_0003, 32'ha004_0004,
               32'ha005_0005, 32'ha006_0006, 32'ha007_0007};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_wa = 2'd0;
        cmd_data = 32'h0;
        repeat (2) @(posedge sclk);
        #1;
        chk("rst_ready", {63'd0, cmd_ready}, 64'd0);
        chk("rst_wen", {63'd0, wen}, 64'd0);
        chk("rst_wa", {62'd0, wa}, 64'd0);
        chk("rst_di", {48'd0, di}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
`ifdef CTRL_WRITER_SHADOW_EN
        rd_wa = 2'd2; #1; chk("rst_shadow2", {32'd0, rd_data}, 64'h0000_00ff);
        rd_wa = 2'd1; #1; chk("rst_shadow1", {32'd0, rd_data}, 64'h0);
`endif
        @(posedge sclk);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // Single write into an idle block.
        send(2'd1, 32'h0040_0007, 0, 2, t);
        wait_idle(ic);
        chk("hold_wa", {62'd0, wa}, 64'd1);
        chk("hold_di", {48'd0, di}, 64'h0040);
        chk("hold_wen", {63'd0, wen}, 64'd0);

        // Four back-to-back commands from idle.
        for (int i = 0; i < 4; i++) send(bw[i], bd[i], (i == 0) ? 0 : 3, (i == 0) ? 2 : 0, t);
        #1;
        chk("burst_busy", {63'd0, busy}, 64'd1);
        wait_idle(ic);
        chk("busy_drop", 64'(ic - last_wen_cyc), 64'd3);

        // Fill the FIFO behind an in-flight command; the 7th waits two cycles while full.
        for (int i = 0; i < 7; i++) begin
            send(fw[i], fd[i], (i == 0) ? 0 : 3, (i == 0) ? 2 : 0, t);
            if (i == 6) chk("full_wait_tries", 64'(t), 64'd3);
        end
        wait_idle(ic);

        // wa=0 passes through unchanged; loopback value for register 2.
        send(2'd0, 32'hdead_beef, 0, 2, t);
        wait_idle(ic);
        send(2'd2, 32'h0000_0155, 0, 2, t);
        wait_idle(ic);
`ifdef CTRL_WRITER_SHADOW_EN
        rd_wa = 2'd2; #1; chk("shadow2", {32'd0, rd_data}, 64'h0000_0155);
        rd_wa = 2'd0; #1; chk("shadow0", {32'd0, rd_data}, 64'hdead_beef);
`endif

        // Reset during the HI cycle abandons the sequence and the queued command.
        @(posedge sclk);
        send(2'd2, 32'h0000_01a5, 0, 2, t);
        send(2'd3, 32'h1234_5678, 3, 0, t);
        @(posedge sclk);
        #1;
        chk("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge sclk);
        #1;
        exp_q.delete();
        saved = wen_count;
        chk("midrst_wen", {63'd0, wen}, 64'd0);
        chk("midrst_di", {48'd0, di}, 64'd0);
        chk("midrst_wa", {62'd0, wa}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_ready", {63'd0, cmd_ready}, 64'd0);
`ifdef CTRL_WRITER_SHADOW_EN
        rd_wa = 2'd2; #1; chk("midrst_shadow2", {32'd0, rd_data}, 64'h0000_00ff);
`endif
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", {63'd0, cmd_ready}, 64'd1);
        repeat (12) @(posedge sclk);
        #1;
        chk("no_wen_after_rst", 64'(wen_count), 64'(saved));
        chk("idle_after_rst", {63'd0, busy}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
